uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the team's UART transmitter, on the far end of the `tx` line.
- Consumes an 8N1-style frame: start bit low, DATA_BITS data bits LSB first, STOP_BITS stop bits high.
- Each bit lasts exactly OVERSAMPLING `clk` cycles, with no baud tick.
- Recovers each byte by mid-bit sampling and presents it with a one-cycle valid pulse plus a framing-error flag.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- OVERSAMPLING, 16, clk cycles per bit; must be even and ≥4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx  input  1  asynchronous serial line, idles high
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame
- valid_out  output  1  one-cycle pulse when data_out has been updated
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- busy  output  1  high while state != IDLE

Behaviour:
- **Clock and reset:** one clock `clk`. Reset `rst` is synchronous and active-high, sampled only on the rising edge of `clk`.
- **Reset values:**
  - data_out = 0, valid_out = 0, frame_err = 0, busy = 0.
  - state = IDLE; all counters = 0.
  - Both synchronizer flops = 1.
- **Reset mid-frame:** abandons the frame; no valid or error pulse is generated.
- **Synchronizer:** rx passes through a 2-FF synchronizer. All logic uses rx_s, the second flop output.
- **Counters:**
  - clk_cnt is $clog2(OVERSAMPLING) bits wide and wraps to 0 after OVERSAMPLING-1.
  - bit_cnt is $clog2(DATA_BITS) bits wide (min 1).
  - shift_reg is DATA_BITS bits wide and shifts right, with the new bit entering at the MSB.
- **IDLE:**
  - busy = 0.
  - If rx_s == 0, set clk_cnt = 0 and go to START.
- **START:**
  - Count clk_cnt up to OVERSAMPLING/2-1 (centre of the start bit).
  - At that count, if rx_s == 1 (glitch), return to IDLE silently.
  - Otherwise set clk_cnt = 0, bit_cnt = 0, and go to DATA.
- **DATA:**
  - At clk_cnt == OVERSAMPLING-1, sample rx_s into the shift_reg MSB and set clk_cnt = 0.
  - If bit_cnt == DATA_BITS-1, set bit_cnt = 0 and go to STOP; else increment bit_cnt.
- **STOP:**
  - At clk_cnt == OVERSAMPLING-1, sample rx_s.
  - If the sample is 0, mark an error.
  - If this is the last stop bit:
    - next cycle, pulse frame_err if any stop sample was 0;
    - otherwise pulse valid_out and load data_out = shift_reg;
    - then go to IDLE.
  - Returning to IDLE at the middle of the last stop bit allows back-to-back frames with zero idle time.
- **Latency:** the rx falling edge is at the pin at cycle 0.
  - valid_out is high in cycle 2 + OVERSAMPLING/2 + (DATA_BITS+STOP_BITS)·OVERSAMPLING.
  - With defaults this is cycle 154.
- **Exclusivity:** valid_out and frame_err are never high together.
- **Backpressure:** none. A consumer that misses the pulse loses the byte; data_out still holds it.
- **Line stuck low:** produces a frame_err for the frame. The receiver then re-enters START immediately and keeps erroring each frame time until the line returns high.

Optional Feature:
- **Macro:** UART_RX_MAJORITY_EN.
- **Defined:**
  - Each bit decision (start check, data, stop) is the 2-of-3 majority of rx_s at clk_cnt = centre-1, centre, centre+1.
  - Decision points shift one cycle later, so total latency is +1 cycle (155 with defaults).
  - Single-cycle glitches at the sample point are rejected.
- **Undefined:** a single sample is taken at the centre, as described above.
- **Both variants:** ports are identical.

Decomposition:
- **Shared package uart_pkg:**
  - State enum typedef (IDLE, START, DATA, STOP) as 2-bit localparam values.
  - Default DATA_BITS / STOP_BITS / OVERSAMPLING constants, also used by the transmitter.
- **Sub-module:** one natural sub-module, sync_2ff (1-bit 2-flop synchronizer with reset value parameter), reused by other async inputs.

Test Plan:
1. **Clean frame:** reset, then drive frame 0xA5 with 16 cycles/bit → exactly one valid_out pulse at cycle 154 after the start edge, data_out = 8'hA5, frame_err stays 0.
2. **Back-to-back frames:** send 0x00, 0xFF, 0x3C with no idle gap → three valid pulses spaced 160 cycles apart, data_out sequence 00, FF, 3C.
3. **Framing error:** send 0x5A with the stop bit driven low → frame_err pulse at cycle 154, valid_out 0, data_out retains previous value.
4. **Start glitch:** rx low for 4 cycles, then high for 200 → no pulses, busy returns to 0 within 11 cycles of the glitch start, state IDLE.
5. **Reset mid-frame:** assert rst for 1 cycle during data bit 3 of 0x81 → no pulses, all outputs at reset values. A following 0x81 frame is received correctly.
6. **Majority (UART_RX_MAJORITY_EN):** with the macro defined, send 0xC3 with a 1-cycle inverted glitch exactly at the centre of every bit → data_out = 8'hC3, valid_out at cycle 155. With the macro undefined, the same stimulus yields a corrupted byte or frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, default frame format,
// and a 2-of-3 majority helper used by the optional vote on bit samples.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_STOP_BITS    = 1;
    localparam int UART_OVERSAMPLING = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte plus status pulses out.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        input  data_out,
        input  valid_out,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output valid_out,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for asynchronous inputs,
// with a configurable value loaded by the synchronous reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled mid-bit UART receiver with valid and framing-error pulses.
// Build macro UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote around the centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = UART_STOP_BITS,
    parameter int OVERSAMPLING = UART_OVERSAMPLING
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
    // The vote needs centre+1, so every decision lands one cycle later
    localparam int START_LAST_I = OVERSAMPLING / 2;
`else
    localparam int START_LAST_I = OVERSAMPLING / 2 - 1;
`endif

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LAST_I);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    logic rx_s;
    logic bit_s;

    uart_state_t          state_r,    state_nx;
    logic [CNT_W-1:0]     clk_cnt_r,  clk_cnt_nx;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_nx;
    logic [DATA_BITS-1:0] shift_r,    shift_nx;
    logic                 stop_cnt_r, stop_cnt_nx;
    logic                 stop_err_r, stop_err_nx;
    logic [DATA_BITS-1:0] data_r,     data_nx;
    logic                 valid_r,    valid_nx;
    logic                 err_r,      err_nx;
    logic                 busy_r,     busy_nx;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Two-deep history of rx_s so the vote spans centre-1 .. centre+1
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign bit_s = maj3(hist_r[1], hist_r[0], rx_s);
`else
    assign bit_s = rx_s;
`endif

    // State and datapath registers, outputs registered straight from next-state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            clk_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            stop_cnt_r <= 1'b0;
            stop_err_r <= 1'b0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            clk_cnt_r  <= clk_cnt_nx;
            bit_cnt_r  <= bit_cnt_nx;
            shift_r    <= shift_nx;
            stop_cnt_r <= stop_cnt_nx;
            stop_err_r <= stop_err_nx;
            data_r     <= data_nx;
            valid_r    <= valid_nx;
            err_r      <= err_nx;
            busy_r     <= busy_nx;
        end
    end

    // Next-state, counters and result pulses
    always_comb begin
        state_nx    = state_r;
        clk_cnt_nx  = clk_cnt_r;
        bit_cnt_nx  = bit_cnt_r;
        shift_nx    = shift_r;
        stop_cnt_nx = stop_cnt_r;
        stop_err_nx = stop_err_r;
        data_nx     = data_r;
        valid_nx    = 1'b0;
        err_nx      = 1'b0;

        case (state_r)
            IDLE: begin
                clk_cnt_nx = '0;
                if (rx_s == 1'b0) begin
                    state_nx = START;
                end else begin
                    state_nx = IDLE;
                end
            end

            START: begin
                if (clk_cnt_r == START_LAST) begin
                    clk_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    if (bit_s == 1'b1) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nx = '0;
                    shift_nx   = {bit_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_nx  = '0;
                        stop_cnt_nx = 1'b0;
                        stop_err_nx = 1'b0;
                        state_nx    = STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nx = '0;
                    // Leaving at the last stop-bit centre allows zero-gap frames
                    if (stop_cnt_r == STOP_LAST) begin
                        state_nx = IDLE;
                        if (stop_err_r || (bit_s == 1'b0)) begin
                            err_nx = 1'b1;
                        end else begin
                            valid_nx = 1'b1;
                            data_nx  = shift_r;
                        end
                    end else begin
                        stop_cnt_nx = stop_cnt_r + 1'b1;
                        stop_err_nx = stop_err_r | ~bit_s;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    assign bus.data_out  = data_r;
    assign bus.valid_out = valid_r;
    assign bus.frame_err = err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DB = UART_DATA_BITS;
    localparam int SB = UART_STOP_BITS;
    localparam int OS = UART_OVERSAMPLING;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int FRAME  = (1 + DB + SB) * OS;
    localparam int LAT    = 2 + OS / 2 + (DB + SB) * OS + MAJ;
    localparam int MAXLEN = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DB)) bus_if ();

    uart_rx #(
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .OVERSAMPLING (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic          line      [MAXLEN];
    logic          exp_valid [MAXLEN];
    logic          exp_err   [MAXLEN];
    logic          exp_busy  [MAXLEN];
    logic [DB-1:0] exp_data  [MAXLEN];
    logic          upd       [MAXLEN];
    logic [DB-1:0] upd_val   [MAXLEN];

    int len;
    int cur_k;
    int n_vec = 0;
    int n_bad = 0;
    int first_valid, last_valid, n_valid, n_err, first_err, last_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cur_k, got, exp);
        end
    endtask

    task automatic put_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (len < MAXLEN) begin
                line[len] = v;
                len++;
            end
        end
    endtask

    task automatic put_frame(input logic [DB-1:0] d, input logic stop_ok);
        put_bits(1'b0, OS);
        for (int i = 0; i < DB; i++) put_bits(d[i], OS);
        for (int j = 0; j < SB; j++) put_bits(stop_ok, OS);
    endtask

    function automatic logic line_at(input int c);
        if (c < 0 || c >= len) return 1'b1;
        return line[c];
    endfunction

    // Value the receiver decides for a bit whose centre is at cycle c
    function automatic logic sample(input int c);
        logic a, b, e;
        a = line_at(c - 1);
        b = line_at(c);
        e = line_at(c + 1);
        if (MAJ != 0) return (a & b) | (a & e) | (b & e);
        return b;
    endfunction

    task automatic mark_busy(input int from, input int upto);
        for (int k = from; k < upto && k < MAXLEN; k++) exp_busy[k] = 1'b1;
    endtask

    // Frame-level decode of the line: start found at t0 is acted on two cycles later
    task automatic build_expected();
        int            t0;
        int            tev;
        logic [DB-1:0] d;
        logic          bad;
        logic [DB-1:0] held;
        for (int k = 0; k < MAXLEN; k++) begin
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
            exp_busy[k]  = 1'b0;
            upd[k]       = 1'b0;
            upd_val[k]   = '0;
        end
        t0 = 0;
        while (t0 < len) begin
            if (line[t0] !== 1'b0) begin
                t0++;
            end else if (sample(t0 + OS / 2) == 1'b1) begin
                mark_busy(t0 + 2, t0 + 2 + OS / 2 + MAJ);
                t0 = t0 + OS / 2 + 1 + MAJ;
            end else begin
                for (int i = 0; i < DB; i++) d[i] = sample(t0 + OS / 2 + OS * (i + 1));
                bad = 1'b0;
                for (int j = 0; j < SB; j++)
                    if (sample(t0 + OS / 2 + OS * (DB + 1 + j)) == 1'b0) bad = 1'b1;
                tev = t0 + LAT;
                mark_busy(t0 + 2, tev);
                if (tev < MAXLEN) begin
                    if (bad) begin
                        exp_err[tev] = 1'b1;
                    end else begin
                        exp_valid[tev] = 1'b1;
                        upd[tev]       = 1'b1;
                        upd_val[tev]   = d;
                    end
                end
                t0 = tev - 1;
            end
        end
        held = '0;
        for (int k = 0; k < MAXLEN; k++) begin
            if (upd[k]) held = upd_val[k];
            exp_data[k] = held;
        end
    endtask

    task automatic run_segment(input string name);
        build_expected();
        first_valid = -1; last_valid = -1; n_valid = 0;
        n_err = 0; first_err = -1; last_busy = -1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bus_if.rx = line[k];
            @(posedge clk);
            #1;
            cur_k = k;
            check_eq({name, "/valid"}, 32'(bus_if.valid_out), 32'(exp_valid[k]));
            check_eq({name, "/err"},   32'(bus_if.frame_err), 32'(exp_err[k]));
            check_eq({name, "/busy"},  32'(bus_if.busy),      32'(exp_busy[k]));
            check_eq({name, "/data"},  32'(bus_if.data_out),  32'(exp_data[k]));
            if (bus_if.valid_out === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                last_valid = k;
                n_valid++;
            end
            if (bus_if.frame_err === 1'b1) begin
                if (first_err < 0) first_err = k;
                n_err++;
            end
            if (bus_if.busy === 1'b1) last_busy = k;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cur_k = -1;
        check_eq("rst/valid", 32'(bus_if.valid_out), 32'd0);
        check_eq("rst/err",   32'(bus_if.frame_err), 32'd0);
        check_eq("rst/busy",  32'(bus_if.busy),      32'd0);
        check_eq("rst/data",  32'(bus_if.data_out),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus_if.rx = 1'b1;
        len       = 0;
    endtask

    initial begin
        int            st;
        int            idx;
        logic [DB-1:0] rd;
        bus_if.rx = 1'b1;
        rst       = 1'b1;
        cur_k     = -1;
        len       = 0;
        repeat (3) @(posedge clk);

        // Clean frame
        do_reset();
        put_bits(1'b1, 20); put_frame(8'hA5, 1'b1); put_bits(1'b1, 40);
        run_segment("clean");
        check_eq("clean_count", n_valid, 1);
        check_eq("clean_lat", first_valid - 20, LAT);
        check_eq("clean_data", 32'(bus_if.data_out), 32'hA5);
        check_eq("clean_err", n_err, 0);

        // Back-to-back frames, no idle gap
        do_reset();
        put_bits(1'b1, 15);
        put_frame(8'h00, 1'b1); put_frame(8'hFF, 1'b1); put_frame(8'h3C, 1'b1);
        put_bits(1'b1, 30);
        run_segment("b2b");
        check_eq("b2b_count", n_valid, 3);
        check_eq("b2b_lat", first_valid - 15, LAT);
        check_eq("b2b_span", last_valid - first_valid, 2 * FRAME);
        check_eq("b2b_data", 32'(bus_if.data_out), 32'h3C);

        // Framing error keeps the previous byte
        do_reset();
        put_bits(1'b1, 10); put_frame(8'h11, 1'b1); put_frame(8'h5A, 1'b0); put_bits(1'b1, 30);
        run_segment("ferr");
        check_eq("ferr_count", n_err, 1);
        check_eq("ferr_lat", first_err - (10 + FRAME), LAT);
        check_eq("ferr_valid", n_valid, 1);
        check_eq("ferr_hold", 32'(bus_if.data_out), 32'h11);

        // Short start glitch
        do_reset();
        put_bits(1'b1, 20); put_bits(1'b0, 4); put_bits(1'b1, 200);
        run_segment("glitch");
        check_eq("glitch_pulses", n_valid + n_err, 0);
        check_eq("glitch_busy_window", 32'(last_busy - 20 < 11), 32'd1);

        // Reset in the middle of data bit 3, then a clean frame
        do_reset();
        put_bits(1'b1, 10); put_frame(8'h81, 1'b1);
        len = 10 + 4 * OS + OS / 2;
        run_segment("midrst");
        check_eq("midrst_pulses", n_valid + n_err, 0);
        do_reset();
        put_bits(1'b1, 20); put_frame(8'h81, 1'b1); put_bits(1'b1, 30);
        run_segment("after_rst");
        check_eq("after_rst_count", n_valid, 1);
        check_eq("after_rst_data", 32'(bus_if.data_out), 32'h81);

        // Inverted single-cycle glitch at every bit centre
        do_reset();
        put_bits(1'b1, 20); put_frame(8'hC3, 1'b1); put_bits(1'b1, 60);
        for (int b = 0; b < 1 + DB + SB; b++) begin
            idx = 20 + OS / 2 + OS * b;
            line[idx] = ~line[idx];
        end
        run_segment("centre_glitch");
`ifdef UART_RX_MAJORITY_EN
        check_eq("maj_count", n_valid, 1);
        check_eq("maj_lat", first_valid - 20, LAT);
        check_eq("maj_data", 32'(bus_if.data_out), 32'hC3);
`endif

        // Line stuck low
        do_reset();
        put_bits(1'b1, 10); put_bits(1'b0, 400); put_bits(1'b1, 300);
        run_segment("stuck");
        check_eq("stuck_errs", 32'(n_err >= 2), 32'd1);

        // Random frames, gaps, bad stops, start glitches and single-cycle noise
        do_reset();
        put_bits(1'b1, 12);
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(3) == 0) begin
                put_bits(1'b0, int'($urandom_range(OS / 2 - 1, 1)));
                put_bits(1'b1, OS + int'($urandom_range(8)));
            end
            st = len;
            rd = DB'($urandom);
            put_frame(rd, $urandom_range(7) != 0);
            if ($urandom_range(3) == 0) begin
                idx = st + int'($urandom_range(FRAME - 1));
                line[idx] = ~line[idx];
            end
            put_bits(1'b1, ($urandom_range(2) == 0) ? 0 : int'($urandom_range(30)));
        end
        put_bits(1'b1, 200);
        run_segment("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
